// File: rtl/mac_lane_acc.sv
// rtl/mac_lane_acc.sv - pipelined multi-lane multiply-accumulate engine
// Two register stages: per-lane products, then tree sum accumulated onto bias/accumulator.
module mac_lane_acc #(
   parameter int LANES    = 4,
   parameter int IN_W     = 8,
   parameter int W_W      = 8,
   parameter int ACC_W    = 32,
   parameter bit SATURATE = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [LANES*IN_W-1:0]  act_i,
   input  logic [LANES*W_W-1:0]   weight_i,
   input  logic                   first_i,
   input  logic                   last_i,
   input  logic [ACC_W-1:0]       bias_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [ACC_W-1:0]       result_o,
   output logic                   sat_o,
   output logic [CNT_W-1:0]       beats_o
);
   localparam int PROD_W = IN_W + W_W + 1;
   localparam int TREE_W = PROD_W + $clog2(LANES);
   localparam int SUM_W  = ACC_W + 1;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                     stall;
   logic signed [PROD_W-1:0] prod    [LANES];
   logic signed [PROD_W-1:0] s1_prod [LANES];
   logic                     s1_valid;
   logic                     s1_first;
   logic                     s1_last;
   logic [ACC_W-1:0]         s1_bias;

   logic signed [TREE_W-1:0] node [2*LANES-1];
   logic signed [TREE_W-1:0] tree_sum;
   logic [ACC_W-1:0]         acc;
   logic [ACC_W-1:0]         base;
   logic signed [SUM_W-1:0]  sum;
   logic                     ovf;
   logic [ACC_W-1:0]         acc_next;
   logic                     flag;
   logic                     flag_next;
   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         cnt_next;

   // A held result freezes the whole pipeline, so no result can ever be dropped.
   assign stall      = out_valid_o & ~out_ready_i;
   assign in_ready_o = ~stall;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod[i] = $signed({{(W_W+1){1'b0}}, act_i[i*IN_W +: IN_W]}) *
                   $signed({{(IN_W+1){weight_i[i*W_W + W_W - 1]}}, weight_i[i*W_W +: W_W]});
      end
   end

   always_ff @(posedge clk_i) begin
      if (!stall) begin
         s1_prod  <= prod;
         s1_first <= first_i;
         s1_last  <= last_i;
         s1_bias  <= bias_i;
      end
   end

   // Heap-ordered adder tree: leaves at LANES-1.., node 0 is the root.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         node[LANES-1+i] = {{(TREE_W-PROD_W){s1_prod[i][PROD_W-1]}}, s1_prod[i]};
      end
      for (int j = LANES - 2; j >= 0; j--) begin
         node[j] = node[2*j+1] + node[2*j+2];
      end
      tree_sum = node[0];
   end

   always_comb begin
      base     = s1_first ? s1_bias : acc;
      sum      = $signed({base[ACC_W-1], base}) +
                 $signed({{(SUM_W-TREE_W){tree_sum[TREE_W-1]}}, tree_sum});
      ovf      = sum[ACC_W] ^ sum[ACC_W-1];
      acc_next = sum[ACC_W-1:0];
      if (SATURATE && ovf) begin
         acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
      flag_next = (s1_first ? 1'b0 : flag) | (SATURATE && ovf);
      if (s1_first) begin
         cnt_next = CNT_W'(1);
      end else if (cnt == CNT_MAX) begin
         cnt_next = cnt;
      end else begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid    <= 1'b0;
         acc         <= '0;
         cnt         <= '0;
         flag        <= 1'b0;
         out_valid_o <= 1'b0;
         result_o    <= '0;
         sat_o       <= 1'b0;
         beats_o     <= '0;
      end else if (!stall) begin
         s1_valid    <= in_valid_i;
         out_valid_o <= s1_valid & s1_last;
         if (s1_valid) begin
            if (s1_last) begin
               result_o <= acc_next;
               sat_o    <= flag_next;
               beats_o  <= cnt_next;
               acc      <= '0;
               cnt      <= '0;
               flag     <= 1'b0;
            end else begin
               acc      <= acc_next;
               cnt      <= cnt_next;
               flag     <= flag_next;
            end
         end
      end
   end

endmodule
